// File: rtl/mod_sysbus_sched.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_sysbus_sched : round-robin scheduler sharing one 64-bit system bus
// between cache-line clients (address beat, 8 write or 8 read beats). Rev 1.0
// ---------------------------------------------------------------------------
module mod_sysbus_sched #(
    parameter int NUM_REQ    = 3,
    parameter int LINE_WIDTH = 512,
    parameter int TAG_WIDTH  = 13
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            cl_reqcyc,
    input  logic [NUM_REQ*64-1:0]         cl_reqaddr,
    input  logic [NUM_REQ*TAG_WIDTH-1:0]  cl_reqtag,
    input  logic [NUM_REQ*LINE_WIDTH-1:0] cl_reqdata,
    output logic [NUM_REQ-1:0]            cl_reqack,
    output logic [NUM_REQ-1:0]            cl_respcyc,
    output logic [LINE_WIDTH-1:0]         cl_resp,
    output logic [TAG_WIDTH-1:0]          cl_resptag,
    output logic [63:0]                   bus_req,
    output logic [TAG_WIDTH-1:0]          bus_reqtag,
    output logic                          bus_reqcyc,
    input  logic                          bus_reqack,
    input  logic [63:0]                   bus_resp,
    input  logic [TAG_WIDTH-1:0]          bus_resptag,
    input  logic                          bus_respcyc,
    output logic                          bus_respack
);

    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        RDATA = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t                state;
    logic [PW-1:0]         rr_ptr;
    logic [PW-1:0]         gnt;
    logic [PW-1:0]         pick;
    logic [PW-1:0]         next_ptr;
    logic                  found;
    logic [2:0]            beat;
    logic [TAG_WIDTH-1:0]  tag;
    logic [LINE_WIDTH-1:0] line;
    logic [LINE_WIDTH-1:0] line_next;
    logic [63:0]           wr_first;
    logic [63:0]           wr_next;
    int                    idx;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [PW-1:0] i);
        onehot    = '0;
        onehot[i] = 1'b1;
    endfunction

    // First asserted request at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && cl_reqcyc[idx]) begin
                found = 1'b1;
                pick  = PW'(idx);
            end
        end
    end

    assign next_ptr    = (int'(pick) == NUM_REQ - 1) ? '0 : pick + 1'b1;
    assign bus_respack = (state == RDATA) && bus_respcyc;

    always_comb begin
        line_next                       = line;
        line_next[int'(beat)*64 +: 64]  = bus_resp;
        wr_first                        = cl_reqdata[int'(gnt)*LINE_WIDTH +: 64];
        wr_next                         = '0;
        if (beat != 3'd7)
            wr_next = cl_reqdata[int'(gnt)*LINE_WIDTH + (int'(beat) + 1)*64 +: 64];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            gnt        <= '0;
            beat       <= '0;
            tag        <= '0;
            line       <= '0;
            cl_reqack  <= '0;
            cl_respcyc <= '0;
            cl_resp    <= '0;
            cl_resptag <= '0;
            bus_req    <= '0;
            bus_reqtag <= '0;
            bus_reqcyc <= 1'b0;
        end else begin
            cl_reqack  <= '0;
            cl_respcyc <= '0;
            case (state)
                IDLE: begin
                    if (found) begin
                        gnt        <= pick;
                        tag        <= cl_reqtag[int'(pick)*TAG_WIDTH +: TAG_WIDTH];
                        cl_reqack  <= onehot(pick);
                        bus_reqcyc <= 1'b1;
                        bus_req    <= cl_reqaddr[int'(pick)*64 +: 64];
                        bus_reqtag <= cl_reqtag[int'(pick)*TAG_WIDTH +: TAG_WIDTH];
                        rr_ptr     <= next_ptr;
                        state      <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus_reqack) begin
                        beat <= '0;
                        if (tag[0]) begin
                            bus_reqcyc <= 1'b0;
                            state      <= RDATA;
                        end else begin
                            bus_req <= wr_first;
                            state   <= WDATA;
                        end
                    end
                end
                WDATA: begin
                    if (bus_reqack) begin
                        if (beat == 3'd7) begin
                            bus_reqcyc <= 1'b0;
                            beat       <= '0;
                            cl_respcyc <= onehot(gnt);
                            cl_resptag <= tag;
                            state      <= DONE;
                        end else begin
                            beat    <= beat + 3'd1;
                            bus_req <= wr_next;
                        end
                    end
                end
                RDATA: begin
                    if (bus_respcyc) begin
                        line <= line_next;
                        if (beat == 3'd7) begin
                            beat       <= '0;
                            tag        <= bus_resptag;
                            cl_respcyc <= onehot(gnt);
                            cl_resptag <= bus_resptag;
                            cl_resp    <= line_next;
                            state      <= DONE;
                        end else begin
                            beat <= beat + 3'd1;
                        end
                    end
                end
                DONE: begin
                    beat  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_sysbus_sched.sv
`default_nettype none
// Self-checking bench for mod_sysbus_sched: table of single transactions plus
// hand sequences for withdrawal, mid-transaction reset and round-robin order.
module tb_mod_sysbus_sched;

    localparam int N  = 3;
    localparam int LW = 512;
    localparam int TW = 13;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      cl_reqcyc;
    logic [N*64-1:0]   cl_reqaddr;
    logic [N*TW-1:0]   cl_reqtag;
    logic [N*LW-1:0]   cl_reqdata;
    logic [N-1:0]      cl_reqack;
    logic [N-1:0]      cl_respcyc;
    logic [LW-1:0]     cl_resp;
    logic [TW-1:0]     cl_resptag;
    logic [63:0]       bus_req;
    logic [TW-1:0]     bus_reqtag;
    logic              bus_reqcyc;
    logic              bus_reqack;
    logic [63:0]       bus_resp;
    logic [TW-1:0]     bus_resptag;
    logic              bus_respcyc;
    logic              bus_respack;

    int passed = 0;
    int total  = 0;
    logic [LW-1:0] exp_resp;

    always #5 clk = ~clk;

    mod_sysbus_sched #(.NUM_REQ(N), .LINE_WIDTH(LW), .TAG_WIDTH(TW)) dut (
        .clk(clk), .reset(reset),
        .cl_reqcyc(cl_reqcyc), .cl_reqaddr(cl_reqaddr), .cl_reqtag(cl_reqtag),
        .cl_reqdata(cl_reqdata), .cl_reqack(cl_reqack), .cl_respcyc(cl_respcyc),
        .cl_resp(cl_resp), .cl_resptag(cl_resptag),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqcyc(bus_reqcyc),
        .bus_reqack(bus_reqack), .bus_resp(bus_resp), .bus_resptag(bus_resptag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack)
    );

    typedef struct {
        int          client;
        logic        rd;
        logic [63:0] addr;
        logic [12:0] tag;
        logic [12:0] rtag;
        logic [63:0] seed;
        int          dly;
        logic        stray;
    } vec_t;

    vec_t vecs[4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        else
            passed++;
    endtask

    function automatic logic [LW-1:0] mk_line(input logic [63:0] seed);
        logic [LW-1:0] l;
        for (int k = 0; k < 8; k++) l[k*64 +: 64] = seed + 64'(k);
        return l;
    endfunction

    task automatic wait_grant(output int who);
        who = -1;
        for (int n = 0; n < 40; n++) begin
            tick();
            if (cl_reqack != '0) begin
                for (int c = 0; c < N; c++) if (cl_reqack[c]) who = c;
                break;
            end
        end
    endtask

    task automatic addr_phase(input int dly);
        for (int d = 0; d < dly; d++) tick();
        chk("addr_hold", bus_reqcyc, 1'b1);
        bus_reqack = 1'b1;
        tick();
        bus_reqack = 1'b0;
    endtask

    task automatic read_beats(input logic [63:0] seed, input logic [12:0] rtag,
                              input int nb, input int gap);
        for (int k = 0; k < nb; k++) begin
            for (int g = 0; g < gap; g++) tick();
            bus_respcyc = 1'b1;
            bus_resp    = seed + 64'(k);
            bus_resptag = rtag;
            #1;
            chk("rd_respack", bus_respack, 1'b1);
            tick();
            bus_respcyc = 1'b0;
        end
    endtask

    task automatic finish_chk(input int c, input logic [12:0] etag);
        chk("resp_pulse", cl_respcyc, 3'b001 << c);
        chk("resp_tag", cl_resptag, etag);
        chk("resp_line", cl_resp, exp_resp);
        tick();
        chk("resp_single", cl_respcyc, 3'b000);
    endtask

    task automatic set_client(input int c, input logic [63:0] a, input logic [12:0] t,
                              input logic [63:0] seed);
        cl_reqaddr[c*64 +: 64] = a;
        cl_reqtag[c*TW +: TW]  = t;
        cl_reqdata[c*LW +: LW] = mk_line(seed);
    endtask

    task automatic run_txn(input vec_t v);
        int who;
        if (v.stray) begin
            bus_respcyc = 1'b1;
            bus_resp    = 64'hDEAD_BEEF_0000_0001;
            bus_resptag = 13'h1FFF;
            #1;
            chk("stray_idle_respack", bus_respack, 1'b0);
            tick();
            bus_respcyc = 1'b0;
        end
        set_client(v.client, v.addr, v.tag, v.seed);
        cl_reqcyc[v.client] = 1'b1;
        wait_grant(who);
        chk("grant", who, v.client);
        cl_reqcyc[v.client] = 1'b0;
        chk("addr_beat", {bus_reqcyc, bus_reqtag, bus_req}, {1'b1, v.tag, v.addr});
        addr_phase(v.dly);
        if (v.rd) begin
            chk("addr_drop", bus_reqcyc, 1'b0);
            read_beats(v.seed, v.rtag, 8, v.dly);
            exp_resp = mk_line(v.seed);
            finish_chk(v.client, v.rtag);
        end else begin
            for (int k = 0; k < 8; k++) begin
                for (int d = 0; d < v.dly; d++) begin
                    if (v.stray && d == 0) begin
                        bus_respcyc = 1'b1;
                        #1;
                        chk("stray_wdata_respack", bus_respack, 1'b0);
                        tick();
                        bus_respcyc = 1'b0;
                    end else begin
                        tick();
                    end
                end
                chk("wr_beat", {bus_reqcyc, bus_req}, {1'b1, v.seed + 64'(k)});
                bus_reqack = 1'b1;
                tick();
                bus_reqack = 1'b0;
            end
            chk("wr_end_cyc", bus_reqcyc, 1'b0);
            finish_chk(v.client, v.tag);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int who;
        int expc;
        logic seen;

        vecs[0] = '{0, 1'b1, 64'h1000, 13'h005, 13'h005, 64'h0, 0, 1'b0};
        vecs[1] = '{1, 1'b0, 64'h2040, 13'h004, 13'h000, 64'hA5A5_A5A5_A5A5_A5A5, 2, 1'b1};
        vecs[2] = '{2, 1'b1, 64'h3000, 13'h0A7, 13'h1A3, 64'h1111_0000, 1, 1'b1};
        vecs[3] = '{0, 1'b0, 64'h40, 13'h1FFE, 13'h000, 64'h5555_0000_0000_0000, 0, 1'b0};

        reset = 1'b0;
        cl_reqcyc = '0; cl_reqaddr = '0; cl_reqtag = '0; cl_reqdata = '0;
        bus_reqack = 1'b0; bus_resp = '0; bus_resptag = '0; bus_respcyc = 1'b0;
        exp_resp = '0;
        repeat (3) tick();
        chk("reset_outs", {cl_reqack, cl_respcyc, cl_resptag, bus_req, bus_reqtag,
                           bus_reqcyc, bus_respack}, '0);
        chk("reset_line", cl_resp, '0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) run_txn(vecs[i]);

        // Client 1 requests and withdraws while client 0 owns the bus.
        set_client(0, 64'h4000, 13'h00B, 64'h7000);
        cl_reqcyc[0] = 1'b1;
        wait_grant(who);
        chk("wd_grant0", who, 0);
        cl_reqcyc[0] = 1'b0;
        cl_reqcyc[1] = 1'b1;
        tick(); 
        cl_reqcyc[1] = 1'b0;
        addr_phase(0);
        read_beats(64'h7000, 13'h00B, 8, 0);
        exp_resp = mk_line(64'h7000);
        finish_chk(0, 13'h00B);
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (cl_reqack != '0) seen = 1'b1;
        end
        chk("wd_no_grant", seen, 1'b0);
        set_client(2, 64'h5000, 13'h00D, 64'h8000);
        cl_reqcyc = 3'b101;
        wait_grant(who);
        chk("wd_rr_ptr", who, 2);
        cl_reqcyc = '0;
        addr_phase(0);
        read_beats(64'h8000, 13'h00D, 8, 0);
        exp_resp = mk_line(64'h8000);
        finish_chk(2, 13'h00D);

        // Reset in the middle of a read.
        set_client(1, 64'h6000, 13'h00F, 64'h9000);
        cl_reqcyc[1] = 1'b1;
        wait_grant(who);
        chk("rst_grant1", who, 1);
        cl_reqcyc[1] = 1'b0;
        addr_phase(0);
        read_beats(64'h9000, 13'h00F, 3, 0);
        reset = 1'b0;
        #1;
        chk("rst_mid_outs", {cl_reqack, cl_respcyc, cl_resptag, bus_req, bus_reqtag,
                             bus_reqcyc}, '0);
        chk("rst_mid_line", cl_resp, '0);
        exp_resp = '0;
        tick();
        reset = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (cl_respcyc != '0) seen = 1'b1;
        end
        chk("rst_no_resp", seen, 1'b0);
        set_client(0, 64'h1100, 13'h013, 64'hA000);
        cl_reqcyc = 3'b101;
        wait_grant(who);
        chk("rst_rr_ptr", who, 0);
        cl_reqcyc = '0;
        addr_phase(0);
        read_beats(64'hA000, 13'h013, 8, 0);
        exp_resp = mk_line(64'hA000);
        finish_chk(0, 13'h013);

        // All clients request continuously; pointer starts at 1 here.
        for (int c = 0; c < N; c++)
            set_client(c, 64'h100 * 64'(c + 1), 13'h011 + 13'(c * 16), 64'hB000 + 64'h100 * 64'(c));
        cl_reqcyc = 3'b111;
        for (int i = 0; i < 6; i++) begin
            expc = (1 + i) % N;
            wait_grant(who);
            chk("rr_order", who, expc);
            chk("rr_addr", bus_req, 64'h100 * 64'(expc + 1));
            addr_phase(0);
            read_beats(64'hB000 + 64'h100 * 64'(expc), 13'h011 + 13'(expc * 16), 8, 0);
            exp_resp = mk_line(64'hB000 + 64'h100 * 64'(expc));
            finish_chk(expc, 13'h011 + 13'(expc * 16));
        end
        cl_reqcyc = '0;
        seen = 1'b0;
        for (int n = 0; n < 3; n++) begin
            tick();
            if (cl_reqack != '0) seen = 1'b1;
        end
        chk("rr_quiet", seen, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
